sync_sp_ram_be_init: RTL and testbench

- Parametrised single-port synchronous RAM wrapper. Successor to the fixed 256x64/45/44 cache SRAM wrappers.
- Honours byte enables per lane, tiles arbitrary widths and depths over la_spram banks, and runs a post-reset init sweep so valid/dirty and tag arrays start from a known value.
- Adds a request/grant handshake and a read-valid strobe.
- Sits between cache controllers (ariane D$/I$ tag, data and valid_dirty arrays) and the la_spram macros.

---
 rtl/sync_sp_ram_be_init_if.sv | 30 +++
 rtl/sync_sp_ram_be_init.sv | 116 +++++++++++
 tb/tb_sync_sp_ram_be_init.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_sp_ram_be_init_if.sv
`timescale 1ns/1ps
// Request/grant bus of the byte-enable RAM wrapper: the cache controller is the master
// and the RAM wrapper is the slave.
interface sync_sp_ram_be_init_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WORDS  = 256
);
  localparam int AW  = ($clog2(NUM_WORDS) < 1) ? 1 : $clog2(NUM_WORDS);
  localparam int NBE = (DATA_WIDTH + 7) / 8;

  logic                  Req_SI;
  logic                  Gnt_SO;
  logic                  WrEn_SI;
  logic [NBE-1:0]        BEn_SI;
  logic [AW-1:0]         Addr_DI;
  logic [DATA_WIDTH-1:0] WrData_DI;
  logic [DATA_WIDTH-1:0] RdData_DO;
  logic                  RdValid_SO;
  logic                  InitDone_SO;

  modport master (
    output Req_SI, WrEn_SI, BEn_SI, Addr_DI, WrData_DI,
    input  Gnt_SO, RdData_DO, RdValid_SO, InitDone_SO
  );

  modport slave (
    input  Req_SI, WrEn_SI, BEn_SI, Addr_DI, WrData_DI,
    output Gnt_SO, RdData_DO, RdValid_SO, InitDone_SO
  );
endinterface

// File: rtl/sync_sp_ram_be_init.sv
`timescale 1ns/1ps
// Single-port RAM with per-byte write enables, tiled over MACRO_DW-wide banks,
// with a post-reset init sweep and a held, strobed read result.
module sync_sp_ram_be_init #(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    NUM_WORDS  = 256,
  parameter int                    MACRO_DW   = 64,
  parameter bit                    INIT_EN    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input logic                  Clk_CI,
  input logic                  Rst_RBI,
  sync_sp_ram_be_init_if.slave bus
);
  localparam int AW  = ($clog2(NUM_WORDS) < 1) ? 1 : $clog2(NUM_WORDS);
  localparam int NBE = (DATA_WIDTH + 7) / 8;
  localparam int NB  = (DATA_WIDTH + MACRO_DW - 1) / MACRO_DW;

  typedef enum logic [1:0] {RESET_WAIT, INIT, READY} state_e;

  function automatic logic [DATA_WIDTH-1:0] expand_be(input logic [NBE-1:0] be);
    logic [DATA_WIDTH-1:0] m;
    for (int b = 0; b < DATA_WIDTH; b++) m[b] = be[b/8];
    return m;
  endfunction

  state_e                state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic                  ready, init_act, accept, in_range, ce, we;
  logic [AW-1:0]         addr;
  logic [DATA_WIDTH-1:0] din, wmask, rd_word, rd_data;
  logic                  rd_vld_p1, oor_p1;
  logic [DATA_WIDTH-1:0] hold_p1;

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      if (INIT_EN) state_q <= INIT;
      else         state_q <= RESET_WAIT;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RESET_WAIT: state_d = READY;
      INIT: begin
        if (cnt_q == AW'(NUM_WORDS - 1)) state_d = READY;
        else                             cnt_d   = cnt_q + 1'b1;
      end
      READY:   state_d = READY;
      default: state_d = READY;
    endcase
  end

  // Non-power-of-two depths can address past the end; those words do not exist.
  if ((2 ** AW) == NUM_WORDS) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    assign in_range = (bus.Addr_DI < AW'(NUM_WORDS));
  end

  always_comb begin
    ready    = (state_q == READY);
    init_act = (state_q == INIT);
    accept   = bus.Req_SI & ready;
    ce       = init_act | accept;
    we       = init_act | (accept & bus.WrEn_SI & in_range);
    addr     = init_act ? cnt_q : bus.Addr_DI;
    din      = init_act ? INIT_VALUE : bus.WrData_DI;
    wmask    = init_act ? {DATA_WIDTH{1'b1}} : expand_be(bus.BEn_SI);
  end

  // Banks share ce/we/addr; bits past DATA_WIDTH in the last bank are never stored.
  for (genvar k = 0; k < NB; k++) begin : g_bank
    localparam int WK = ((k + 1) * MACRO_DW > DATA_WIDTH) ? DATA_WIDTH - k * MACRO_DW : MACRO_DW;
    logic [WK-1:0] mem [NUM_WORDS];
    logic [WK-1:0] din_k, mask_k, dout_p1;

    assign din_k  = din[k*MACRO_DW +: WK];
    assign mask_k = wmask[k*MACRO_DW +: WK];

    always_ff @(posedge Clk_CI) begin
      if (ce && we)  mem[addr] <= (mem[addr] & ~mask_k) | (din_k & mask_k);
      if (ce && !we) dout_p1   <= mem[addr];
    end

    assign rd_word[k*MACRO_DW +: WK] = dout_p1;
  end

  // ---- stage p1: read strobe, out-of-range flag, held result ----
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      rd_vld_p1 <= 1'b0;
      hold_p1   <= '0;
    end else begin
      rd_vld_p1 <= accept & ~bus.WrEn_SI;
      if (rd_vld_p1) hold_p1 <= rd_data;
    end
  end

  always_ff @(posedge Clk_CI) begin
    oor_p1 <= ~in_range;
  end

  assign rd_data = rd_vld_p1 ? (oor_p1 ? '0 : rd_word) : hold_p1;

  assign bus.Gnt_SO      = ready;
  assign bus.InitDone_SO = ready;
  assign bus.RdValid_SO  = rd_vld_p1;
  assign bus.RdData_DO   = rd_data;
endmodule

// File: tb/tb_sync_sp_ram_be_init.sv
`timescale 1ns/1ps
// Bench for sync_sp_ram_be_init: a 64x256 initialised instance and a 45x200 uninitialised one,
// checked against a byte-lane memory model.
module tb_sync_sp_ram_be_init;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int   n_chk  = 0;
  int   n_fail = 0;

  sync_sp_ram_be_init_if #(.DATA_WIDTH(64), .NUM_WORDS(256)) bus_a ();
  sync_sp_ram_be_init_if #(.DATA_WIDTH(45), .NUM_WORDS(200)) bus_b ();

  sync_sp_ram_be_init #(
    .DATA_WIDTH(64), .NUM_WORDS(256), .MACRO_DW(64), .INIT_EN(1'b1), .INIT_VALUE(64'hA5)
  ) dut_a (.Clk_CI(clk), .Rst_RBI(rst_a), .bus(bus_a));

  sync_sp_ram_be_init #(
    .DATA_WIDTH(45), .NUM_WORDS(200), .MACRO_DW(32), .INIT_EN(1'b0), .INIT_VALUE(45'h0)
  ) dut_b (.Clk_CI(clk), .Rst_RBI(rst_b), .bus(bus_b));

  logic [63:0] ref_a [256];
  logic [63:0] hold_a;
  logic [63:0] ref_b [200];
  logic [44:0] hold_b;

  localparam logic [63:0] D1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D2 = 64'hFEDC_BA98_7654_3210;

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  task automatic drive_a(input logic req, input logic wr, input logic [7:0] be,
                         input logic [7:0] addr, input logic [63:0] data);
    bus_a.Req_SI = req; bus_a.WrEn_SI = wr; bus_a.BEn_SI = be;
    bus_a.Addr_DI = addr; bus_a.WrData_DI = data;
    bus_b.Req_SI = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic drive_b(input logic req, input logic wr, input logic [5:0] be,
                         input logic [7:0] addr, input logic [44:0] data);
    bus_b.Req_SI = req; bus_b.WrEn_SI = wr; bus_b.BEn_SI = be;
    bus_b.Addr_DI = addr; bus_b.WrData_DI = data;
    bus_a.Req_SI = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    bus_a.Req_SI = 0; bus_a.WrEn_SI = 0; bus_a.BEn_SI = '0; bus_a.Addr_DI = '0; bus_a.WrData_DI = '0;
    bus_b.Req_SI = 0; bus_b.WrEn_SI = 0; bus_b.BEn_SI = '0; bus_b.Addr_DI = '0; bus_b.WrData_DI = '0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({bus_a.Gnt_SO, bus_a.RdValid_SO, bus_a.InitDone_SO, bus_a.RdData_DO} !== 67'h0) begin
      n_fail++;
      $display("FAIL reset_a: gnt/vld/done/data got %b%b%b %h, expected 000 0",
               bus_a.Gnt_SO, bus_a.RdValid_SO, bus_a.InitDone_SO, bus_a.RdData_DO);
    end
    n_chk++;
    if ({bus_b.Gnt_SO, bus_b.RdValid_SO, bus_b.InitDone_SO, bus_b.RdData_DO} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_b: gnt/vld/done/data got %b%b%b %h, expected 000 0",
               bus_b.Gnt_SO, bus_b.RdValid_SO, bus_b.InitDone_SO, bus_b.RdData_DO);
    end
  endtask

  task automatic test_init_sweep();
    int   cnt = 0;
    logic seen_vld = 1'b0;
    // a write held through the sweep must be ignored
    bus_a.Req_SI = 1; bus_a.WrEn_SI = 1; bus_a.BEn_SI = 8'hFF; bus_a.Addr_DI = 8'd0;
    bus_a.WrData_DI = 64'hDEAD_BEEF_0BAD_F00D;
    rst_a = 1'b1; rst_b = 1'b1;
    n_chk++;
    if (bus_b.Gnt_SO !== 1'b0) begin
      n_fail++; $display("FAIL b_gnt_after_release: got %b, expected 0", bus_b.Gnt_SO);
    end
    while (bus_a.Gnt_SO === 1'b0 && cnt < 400) begin
      cnt++;
      if (bus_a.RdValid_SO !== 1'b0) seen_vld = 1'b1;
      @(posedge clk); @(negedge clk);
      if (cnt == 1) begin
        n_chk++;
        if ({bus_b.Gnt_SO, bus_b.InitDone_SO} !== 2'b11) begin
          n_fail++; $display("FAIL b_ready_one_cycle: gnt/done got %b%b, expected 11",
                             bus_b.Gnt_SO, bus_b.InitDone_SO);
        end
      end
    end
    bus_a.Req_SI = 1'b0;
    n_chk++;
    if (cnt !== 256) begin
      n_fail++; $display("FAIL sweep_len: got %0d cycles, expected 256", cnt);
    end
    n_chk++;
    if (seen_vld !== 1'b0 || bus_a.InitDone_SO !== 1'b1) begin
      n_fail++; $display("FAIL sweep_flags: vld_seen %b done %b, expected 0 1",
                         seen_vld, bus_a.InitDone_SO);
    end
    for (int i = 0; i < 256; i++) ref_a[i] = 64'hA5;
    hold_a = '0;
    for (int j = 0; j < 4; j++) begin
      logic [7:0] ad;
      ad = (j == 0) ? 8'd0 : (j == 1) ? 8'd128 : (j == 2) ? 8'd255 : 8'd77;
      drive_a(1'b1, 1'b0, 8'h00, ad, 64'h0);
      hold_a = ref_a[ad];
      n_chk++;
      if (bus_a.RdValid_SO !== 1'b1 || bus_a.RdData_DO !== 64'hA5) begin
        n_fail++; $display("FAIL init_read[%0d]: vld %b data %h, expected 1 a5",
                           ad, bus_a.RdValid_SO, bus_a.RdData_DO);
      end
    end
  endtask

  task automatic test_byte_enables();
    drive_a(1'b1, 1'b1, 8'hFF, 8'd3, 64'h1122_3344_5566_7788);
    ref_a[3] = merge(ref_a[3], 64'h1122_3344_5566_7788, 8'hFF);
    n_chk++;
    if (bus_a.RdValid_SO !== 1'b0 || bus_a.RdData_DO !== hold_a) begin
      n_fail++; $display("FAIL write_no_vld: vld %b data %h, expected 0 %h",
                         bus_a.RdValid_SO, bus_a.RdData_DO, hold_a);
    end
    drive_a(1'b1, 1'b1, 8'b0000_0101, 8'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    ref_a[3] = merge(ref_a[3], 64'hFFFF_FFFF_FFFF_FFFF, 8'b0000_0101);
    drive_a(1'b1, 1'b1, 8'h00, 8'd3, 64'h0);
    drive_a(1'b1, 1'b0, 8'h00, 8'd3, 64'h0);
    hold_a = ref_a[3];
    n_chk++;
    if (bus_a.RdValid_SO !== 1'b1 || bus_a.RdData_DO !== 64'h1122_3344_55FF_77FF) begin
      n_fail++; $display("FAIL byte_en: vld %b data %h, expected 1 112233445 5ff77ff",
                         bus_a.RdValid_SO, bus_a.RdData_DO);
    end
  endtask

  task automatic test_odd_geometry();
    logic [44:0] ones = 45'h1F_FFFF_FFFF_FF;
    drive_b(1'b1, 1'b1, 6'h3F, 8'd199, ones);
    drive_b(1'b1, 1'b0, 6'h00, 8'd199, 45'h0);
    n_chk++;
    if (bus_b.RdValid_SO !== 1'b1 || bus_b.RdData_DO !== ones) begin
      n_fail++; $display("FAIL odd_last_word: vld %b data %h, expected 1 %h",
                         bus_b.RdValid_SO, bus_b.RdData_DO, ones);
    end
    ref_b[50] = {19'h0, ones};
    drive_b(1'b1, 1'b1, 6'h3F, 8'd50, ones);
    drive_b(1'b1, 1'b1, 6'b100000, 8'd50, 45'h0);
    ref_b[50] = merge(ref_b[50], 64'h0, 8'b0010_0000);
    drive_b(1'b1, 1'b1, 6'b010001, 8'd50, 45'h0);
    ref_b[50] = merge(ref_b[50], 64'h0, 8'b0001_0001);
    drive_b(1'b1, 1'b0, 6'h00, 8'd50, 45'h0);
    n_chk++;
    if (bus_b.RdData_DO !== ref_b[50][44:0] || bus_b.RdData_DO !== 45'h0000_FFFF_FF00) begin
      n_fail++; $display("FAIL odd_partial_be: data %h, expected 0000ffffff00", bus_b.RdData_DO);
    end
    drive_b(1'b1, 1'b1, 6'h3F, 8'd210, ones);
    n_chk++;
    if (bus_b.Gnt_SO !== 1'b1 || bus_b.RdValid_SO !== 1'b0) begin
      n_fail++; $display("FAIL oor_write: gnt %b vld %b, expected 1 0", bus_b.Gnt_SO, bus_b.RdValid_SO);
    end
    drive_b(1'b1, 1'b0, 6'h00, 8'd210, 45'h0);
    n_chk++;
    if (bus_b.RdValid_SO !== 1'b1 || bus_b.RdData_DO !== 45'h0) begin
      n_fail++; $display("FAIL oor_read: vld %b data %h, expected 1 0", bus_b.RdValid_SO, bus_b.RdData_DO);
    end
    drive_b(1'b0, 1'b0, 6'h00, 8'd0, 45'h0);
    n_chk++;
    if (bus_b.RdValid_SO !== 1'b0 || bus_b.RdData_DO !== 45'h0) begin
      n_fail++; $display("FAIL oor_hold: vld %b data %h, expected 0 0", bus_b.RdValid_SO, bus_b.RdData_DO);
    end
    drive_b(1'b1, 1'b0, 6'h00, 8'd199, 45'h0);
    bus_b.Req_SI = 1'b0;
    n_chk++;
    if (bus_b.RdData_DO !== ones) begin
      n_fail++; $display("FAIL odd_reread: data %h, expected %h", bus_b.RdData_DO, ones);
    end
  endtask

  task automatic test_back_to_back();
    drive_a(1'b1, 1'b1, 8'hFF, 8'd7, D1);
    drive_a(1'b1, 1'b0, 8'h00, 8'd7, 64'h0);
    n_chk++;
    if (bus_a.RdValid_SO !== 1'b1 || bus_a.RdData_DO !== D1) begin
      n_fail++; $display("FAIL wr_then_rd: vld %b data %h, expected 1 %h", bus_a.RdValid_SO, bus_a.RdData_DO, D1);
    end
    drive_a(1'b1, 1'b0, 8'h00, 8'd7, 64'h0);
    n_chk++;
    if (bus_a.RdData_DO !== D1) begin
      n_fail++; $display("FAIL rd_before_wr: data %h, expected %h", bus_a.RdData_DO, D1);
    end
    drive_a(1'b1, 1'b1, 8'hFF, 8'd7, D2);
    ref_a[7] = D2;
    hold_a = D1;
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (bus_a.RdValid_SO !== 1'b0 || bus_a.RdData_DO !== D1) begin
        n_fail++; $display("FAIL hold_d1[%0d]: vld %b data %h, expected 0 %h",
                           i, bus_a.RdValid_SO, bus_a.RdData_DO, D1);
      end
      if (i < 5) drive_a(1'b0, 1'b0, 8'h00, 8'd0, 64'h0);
    end
    drive_a(1'b1, 1'b0, 8'h00, 8'd7, 64'h0);
    hold_a = D2;
    n_chk++;
    if (bus_a.RdData_DO !== D2) begin
      n_fail++; $display("FAIL read_d2: data %h, expected %h", bus_a.RdData_DO, D2);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic req, wr;
      logic [7:0] be, ad;
      logic [63:0] d;
      req = ($urandom_range(0, 3) != 0);
      wr  = 1'($urandom_range(0, 1));
      be  = 8'($urandom);
      ad  = (i % 4 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      d   = {$urandom, $urandom};
      if (req && !wr) hold_a = ref_a[ad];
      if (req && wr)  ref_a[ad] = merge(ref_a[ad], d, be);
      drive_a(req, wr, be, ad, d);
      n_chk++;
      if (bus_a.RdValid_SO !== (req & ~wr) || bus_a.RdData_DO !== hold_a) begin
        n_fail++; $display("FAIL random[%0d]: vld %b data %h, expected %b %h",
                           i, bus_a.RdValid_SO, bus_a.RdData_DO, req & ~wr, hold_a);
      end
    end
    bus_a.Req_SI = 1'b0;
  endtask

  task automatic test_reset_after_read();
    drive_a(1'b1, 1'b0, 8'h00, 8'd7, 64'h0);
    n_chk++;
    if (bus_a.RdValid_SO !== 1'b1 || bus_a.RdData_DO !== ref_a[7]) begin
      n_fail++; $display("FAIL pre_reset_read: vld %b data %h, expected 1 %h",
                         bus_a.RdValid_SO, bus_a.RdData_DO, ref_a[7]);
    end
    bus_a.Req_SI = 1'b0;
    rst_a = 1'b0;
    @(posedge clk); @(negedge clk);
    n_chk++;
    if ({bus_a.Gnt_SO, bus_a.RdValid_SO, bus_a.RdData_DO} !== 66'h0) begin
      n_fail++; $display("FAIL reset_after_read: gnt %b vld %b data %h, expected 0 0 0",
                         bus_a.Gnt_SO, bus_a.RdValid_SO, bus_a.RdData_DO);
    end
  endtask

  task automatic test_reset_mid_init();
    int   cnt = 0;
    logic seen_vld = 1'b0;
    bus_a.Req_SI = 1; bus_a.WrEn_SI = 0; bus_a.BEn_SI = 8'hFF; bus_a.Addr_DI = 8'd1;
    rst_a = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (bus_a.RdValid_SO !== 1'b0 || bus_a.Gnt_SO !== 1'b0) seen_vld = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    rst_a = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_a = 1'b1;
    while (bus_a.Gnt_SO === 1'b0 && cnt < 400) begin
      cnt++;
      if (bus_a.RdValid_SO !== 1'b0) seen_vld = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    bus_a.Req_SI = 1'b0;
    n_chk++;
    if (cnt !== 256) begin
      n_fail++; $display("FAIL restart_sweep_len: got %0d cycles, expected 256", cnt);
    end
    n_chk++;
    if (seen_vld !== 1'b0) begin
      n_fail++; $display("FAIL req_during_init: activity seen %b, expected 0", seen_vld);
    end
    for (int i = 0; i < 256; i++) ref_a[i] = 64'hA5;
    drive_a(1'b1, 1'b0, 8'h00, 8'd7, 64'h0);
    bus_a.Req_SI = 1'b0;
    n_chk++;
    if (bus_a.RdValid_SO !== 1'b1 || bus_a.RdData_DO !== ref_a[7]) begin
      n_fail++; $display("FAIL post_restart_read: vld %b data %h, expected 1 %h",
                         bus_a.RdValid_SO, bus_a.RdData_DO, ref_a[7]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init_sweep();
    test_byte_enables();
    test_odd_geometry();
    test_back_to_back();
    test_random();
    test_reset_after_read();
    test_reset_mid_init();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
